// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Brings the system PLL from power-up to run on the free-running reference
//   clock. It pulses the PLL reset and waits for lock. It retries the PLL when
//   lock does not arrive in time. It then requires lock to stay stable before
//   it releases the core reset. Loss of lock or a software restart starts the
//   whole sequence again.
//
// Ports
//   refclk       in   1  reference clock; the only clock of this block
//   rst          in   1  synchronous, active-high reset
//   pll_locked   in   1  PLL locked flag; asynchronous to refclk
//   restart_req  in   1  single-cycle pulse; forces a full PLL restart
//   pll_rst      out  1  PLL reset, active-high
//   sys_rst      out  1  core reset, active-high; low only in RUN
//   ready        out  1  high only in RUN
//   lock_lost    out  1  one-cycle pulse when lock drops while in RUN
//   retry_count  out  8  lock timeouts since rst, saturating at 255
//
// All outputs are registered. The outputs that follow the state are computed
// from next_state, so they change on the same edge as the state register.

module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] retry_count
);

    // The counter only ever has to reach (largest parameter - 1).
    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_PLLRST = 2'd0,
        S_WAIT   = 2'd1,
        S_STABLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             timeout;

    logic             lock_sync_p0;
    logic             lock_sync_p1;
    logic             locked_s;

    logic             pll_rst_nxt;
    logic             sys_rst_nxt;
    logic             ready_nxt;
    logic             lock_lost_nxt;
    logic [7:0]       retry_nxt;

    // Lock synchronizer: stage 0 may go metastable, stage 1 is the qualified flag.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_sync_p0 <= 1'b0;
            lock_sync_p1 <= 1'b0;
        end else begin
            lock_sync_p0 <= pll_locked;
            lock_sync_p1 <= lock_sync_p0;
        end
    end

    assign locked_s = lock_sync_p1;

    // State register and registered outputs
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= S_PLLRST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= 8'd0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_nxt;
            pll_rst     <= pll_rst_nxt;
            sys_rst     <= sys_rst_nxt;
            ready       <= ready_nxt;
            lock_lost   <= lock_lost_nxt;
            retry_count <= retry_nxt;
        end
    end

    // Next-state and shared counter
    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        if (restart_req) begin
            next_state = S_PLLRST;
        end else begin
            case (state)
                S_PLLRST: begin
                    if (cnt == RST_LAST) begin
                        next_state = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (locked_s) begin
                        next_state = S_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        next_state = S_PLLRST;
                        timeout    = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        next_state = S_WAIT;
                    end else if (cnt == STABLE_LAST) begin
                        next_state = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        next_state = S_PLLRST;
                    end
                end
                default: next_state = S_PLLRST;
            endcase
        end

        // A restart inside PLLRST keeps the state, but it must still clear the
        // count so that the PLL reset is re-timed from the pulse. RUN does not
        // use the counter, so the counter holds there instead of wrapping.
        if (restart_req || (next_state != state)) begin
            cnt_nxt = '0;
        end else if (state == S_RUN) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // Output next-values
    always_comb begin
        pll_rst_nxt   = (next_state == S_PLLRST);
        sys_rst_nxt   = (next_state != S_RUN);
        ready_nxt     = (next_state == S_RUN);
        // A lock drop in RUN is reported even when a restart wins the transition.
        lock_lost_nxt = (state == S_RUN) && !locked_s;
        retry_nxt     = retry_count;
        if (timeout && (retry_count != 8'hFF)) begin
            retry_nxt = retry_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer with small parameters (4 / 20 / 8).
// It uses a vector table for power-up with a steady lock, hand-written
// sequences for the multi-cycle corner cases, and a randomized run against a
// cycle-count reference model.
module tb_pll_reset_sequencer;

    localparam int PRC = 4;
    localparam int LTO = 20;
    localparam int STC = 8;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [7:0] retry_count;

    int checks = 0;
    int failures = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LTO),
        .STABLE_CYCLES (STC)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart_req(restart_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .retry_count(retry_count)
    );

    always #5 refclk = ~refclk;

    // Advance past one active edge; outputs are then sampled and inputs driven.
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {pll_rst, sys_rst, ready, lock_lost, retry_count};
    endfunction

    // Reference model: the phase the sequencer is in and how many cycles it
    // has spent there, plus a two-deep delay line for the lock flag.
    localparam int PH_PLLRST = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;

    int   m_phase;
    int   m_spent;
    int   m_retry;
    bit   m_lost;
    bit   m_dly[2];

    task automatic model_step(input bit r, input bit lk, input bit rq);
        bit ls;
        ls = m_dly[1];
        if (r) begin
            m_phase = PH_PLLRST; m_spent = 0; m_retry = 0; m_lost = 0;
            m_dly[0] = 0; m_dly[1] = 0;
            return;
        end
        m_lost = (m_phase == PH_RUN) && !ls;
        if (rq) begin
            m_phase = PH_PLLRST; m_spent = 0;
        end else if (m_phase == PH_PLLRST) begin
            m_spent++;
            if (m_spent == PRC) begin m_phase = PH_WAIT; m_spent = 0; end
        end else if (m_phase == PH_WAIT) begin
            if (ls) begin
                m_phase = PH_STABLE; m_spent = 0;
            end else begin
                m_spent++;
                if (m_spent == LTO) begin
                    m_phase = PH_PLLRST; m_spent = 0;
                    if (m_retry < 255) m_retry++;
                end
            end
        end else if (m_phase == PH_STABLE) begin
            if (!ls) begin
                m_phase = PH_WAIT; m_spent = 0;
            end else begin
                m_spent++;
                if (m_spent == STC) begin m_phase = PH_RUN; m_spent = 0; end
            end
        end else begin
            if (!ls) begin m_phase = PH_PLLRST; m_spent = 0; end
        end
        m_dly[1] = m_dly[0];
        m_dly[0] = lk;
    endtask

    function automatic logic [11:0] model_outs();
        logic [7:0] rc;
        rc = 8'(m_retry);
        return {m_phase == PH_PLLRST, m_phase != PH_RUN, m_phase == PH_RUN, m_lost, rc};
    endfunction

    typedef struct {
        bit          rst;
        bit          lk;
        bit          rq;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[18];

    initial begin
        bit cur_lk;
        bit r;
        bit rq;

        // Power-up with lock already present. Entry 0 is a reset edge; entry k
        // (k>=1) is edge k-1 after release, whose outputs show cycle k.
        for (int k = 0; k < 18; k++) begin
            vecs[k].rst = (k == 0);
            vecs[k].lk  = 1'b1;
            vecs[k].rq  = 1'b0;
            if (k == 0) begin
                vecs[k].exp = {1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
            end else begin
                vecs[k].exp = {(k - 1) <= 2, (k - 1) < 12, (k - 1) >= 12, 1'b0, 8'd0};
            end
        end
        for (int k = 0; k < 18; k++) begin
            rst = vecs[k].rst; pll_locked = vecs[k].lk; restart_req = vecs[k].rq;
            tick();
            check($sformatf("powerup_v%0d", k), outs(), vecs[k].exp);
        end

        // Lock drop in RUN: two sync edges, then the transition edge.
        pll_locked = 0;
        tick(); check("drop_sync0_ready", ready, 1);
        tick(); check("drop_sync1_lost", lock_lost, 0);
        tick(); check("drop_edge", outs(), {1'b1, 1'b1, 1'b0, 1'b1, 8'd0});
        tick(); check("drop_lost_once", lock_lost, 0);
        tick(); tick(); check("drop_pllrst_4th", pll_rst, 1);
        tick(); check("drop_pllrst_end", pll_rst, 0);

        // No lock at all: timeouts, then saturation.
        rst = 1; pll_locked = 0; tick(); rst = 0;
        for (int e = 0; e <= 6200; e++) begin
            tick();
            if (e == 2)    check("to_pllrst_c3", pll_rst, 1);
            if (e == 3)    check("to_pllrst_c4", pll_rst, 0);
            if (e == 22)   check("to_wait_c23", {pll_rst, retry_count}, {1'b0, 8'd0});
            if (e == 23)   check("to_first_retry", {pll_rst, retry_count}, {1'b1, 8'd1});
            if (e == 6095) check("to_retry_254", retry_count, 254);
            if (e == 6119) check("to_retry_255", retry_count, 255);
            if (e == 6200) check("to_retry_sat", retry_count, 255);
        end

        // One-cycle lock loss inside STABLE.
        rst = 1; pll_locked = 1; tick(); rst = 0;
        for (int e = 0; e <= 5; e++) tick();
        pll_locked = 0; tick(); pll_locked = 1;
        for (int e = 7; e <= 17; e++) begin
            tick();
            if (e == 10) check("glitch_no_pllrst", pll_rst, 0);
            if (e == 12) check("glitch_not_run_yet", ready, 0);
            if (e == 16) check("glitch_ready_late", ready, 0);
            if (e == 17) check("glitch_run", {ready, sys_rst, retry_count}, {1'b1, 1'b0, 8'd0});
        end

        // Restart in RUN, then a second restart during PLLRST.
        restart_req = 1; tick(); restart_req = 0;
        check("restart_edge", {pll_rst, sys_rst, ready}, 3'b110);
        tick();
        restart_req = 1; tick(); restart_req = 0;
        tick(); tick(); tick();
        check("restart_ext", pll_rst, 1);
        tick();
        check("restart_end", {pll_rst, retry_count}, {1'b0, 8'd0});

        // Restart coinciding with a lock drop in RUN still reports the drop.
        for (int e = 25; e <= 33; e++) tick();
        check("prio_in_run", ready, 1);
        pll_locked = 0; tick(); tick();
        restart_req = 1; tick(); restart_req = 0;
        check("prio_lost", {pll_rst, lock_lost}, 2'b11);

        // rst while in STABLE after one retry.
        rst = 1; pll_locked = 0; tick(); rst = 0;
        for (int e = 0; e <= 23; e++) tick();
        check("rst_pre_retry", retry_count, 1);
        pll_locked = 1;
        for (int e = 24; e <= 30; e++) tick();
        check("rst_in_stable", {pll_rst, ready}, 2'b00);
        rst = 1; tick(); rst = 0;
        check("rst_mid", outs(), {1'b1, 1'b1, 1'b0, 1'b0, 8'd0});

        // Randomized run against the model.
        cur_lk = 1;
        for (int i = 0; i < 4000; i++) begin
            r = (i == 0) || ($urandom_range(999) == 0);
            if (cur_lk) begin
                if ($urandom_range(59) == 0) cur_lk = 0;
            end else if ($urandom_range(9) == 0) begin
                cur_lk = 1;
            end
            rq = ($urandom_range(299) == 0);
            rst = r; pll_locked = cur_lk; restart_req = rq;
            model_step(r, cur_lk, rq);
            tick();
            check($sformatf("rand_%0d", i), outs(), model_outs());
        end
        rst = 0; restart_req = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
